// File: rtl/fc_operand_feeder.sv
// fc_operand_feeder
//   Runs one fully-connected accumulation job into the FC MAC core. On an
//   accepted start it clears the core and reads the node/weight operand
//   pairs from two synchronous single-port memories. It streams those pairs
//   with the layer bias into the core, then captures the core's result.
//
// Build option:
//   FC_BIAS_ONCE_EN  defined   -> bias is presented on the first valid beat only
//                    undefined -> bias is presented on every valid beat
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   i_start, i_len, i_bias     job request, beat count, layer bias (sampled at start)
//   o_idle, o_done, o_result   controller status and captured accumulation
//   o_node_ce/o_wegt_ce        memory read enables
//   o_node_addr/o_wegt_addr    memory read addresses (always identical)
//   i_node_q, i_wegt_q         memory read data, one cycle after ce/addr
//   o_run                      core clear pulse
//   o_valid, o_node, o_wegt,
//   o_bias                     core operand beat
//   i_core_result              core accumulator output
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for i_start; len/bias latched on acceptance
// S_CLEAR | one cycle, o_run=1 clears the core accumulator
// S_FETCH | len cycles, one memory read per cycle at addr 0..len-1
// S_DRAIN | two cycles, last beat lands in core; capture at end of 2nd
// S_DONE  | one cycle, o_done=1, o_result valid

module fc_operand_feeder #(
  parameter int IN_DATA_WIDTH = 16,
  parameter int NUM_NODE      = 64,
  parameter int ADDR_WIDTH    = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH:0]        i_len,
  input  logic [IN_DATA_WIDTH-1:0]   i_bias,
  output logic                       o_idle,
  output logic                       o_done,
  output logic [4*IN_DATA_WIDTH-1:0] o_result,
  output logic                       o_node_ce,
  output logic                       o_wegt_ce,
  output logic [ADDR_WIDTH-1:0]      o_node_addr,
  output logic [ADDR_WIDTH-1:0]      o_wegt_addr,
  input  logic [IN_DATA_WIDTH-1:0]   i_node_q,
  input  logic [IN_DATA_WIDTH-1:0]   i_wegt_q,
  output logic                       o_run,
  output logic                       o_valid,
  output logic [IN_DATA_WIDTH-1:0]   o_node,
  output logic [IN_DATA_WIDTH-1:0]   o_wegt,
  output logic [IN_DATA_WIDTH-1:0]   o_bias,
  input  logic [4*IN_DATA_WIDTH-1:0] i_core_result
);

  localparam int                  RES_WIDTH = 4*IN_DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEN_MAX   = (ADDR_WIDTH+1)'(NUM_NODE);
  localparam logic [ADDR_WIDTH:0] LEN_ONE   = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                 state_q;
  state_t                 state_d;

  logic [ADDR_WIDTH:0]    len_clamped;
  logic [ADDR_WIDTH:0]    beats_q;     // fetch beats still to issue
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   drain_q;     // drain down-counter, terminal at 0
  logic [IN_DATA_WIDTH-1:0] bias_q;
  logic                   valid_q;
  logic [RES_WIDTH-1:0]   result_q;
  logic                   ce;
  logic                   run;
  logic                   done;
`ifdef FC_BIAS_ONCE_EN
  logic                   first_q;     // current valid beat came from address 0
`endif

  assign len_clamped = (i_len > LEN_MAX) ? LEN_MAX : i_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ce      = 1'b0;
    run     = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        run     = 1'b1;
        state_d = (beats_q == '0) ? S_DRAIN : S_FETCH;
      end
      S_FETCH: begin
        ce = 1'b1;
        if (beats_q == LEN_ONE) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q == 1'b0) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beats_q  <= '0;
      addr_q   <= '0;
      drain_q  <= 1'b1;
      bias_q   <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= ce;
      // Preloaded outside DRAIN so the two drain cycles need no entry logic.
      drain_q <= (state_q == S_DRAIN) ? drain_q - 1'b1 : 1'b1;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            beats_q <= len_clamped;
            bias_q  <= i_bias;
            addr_q  <= '0;
          end
        end
        S_FETCH: begin
          addr_q  <= addr_q + 1'b1;
          beats_q <= beats_q - 1'b1;
        end
        default: ;
      endcase
      // Second drain cycle: the core has absorbed the final beat.
      if (state_q == S_DRAIN && drain_q == 1'b0) result_q <= i_core_result;
    end
  end

`ifdef FC_BIAS_ONCE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_q <= 1'b0;
    end else begin
      first_q <= ce && (addr_q == '0);
    end
  end
`endif

  assign o_idle      = (state_q == S_IDLE);
  assign o_done      = done;
  assign o_run       = run;
  assign o_result    = result_q;
  assign o_node_ce   = ce;
  assign o_wegt_ce   = ce;
  assign o_node_addr = ce ? addr_q : '0;
  assign o_wegt_addr = ce ? addr_q : '0;
  assign o_valid     = valid_q;
  // Read data is only meaningful on valid beats; zero otherwise so the core
  // and reset view never see stale memory output.
  assign o_node      = valid_q ? i_node_q : '0;
  assign o_wegt      = valid_q ? i_wegt_q : '0;
`ifdef FC_BIAS_ONCE_EN
  assign o_bias      = (valid_q && first_q) ? bias_q : '0;
`else
  assign o_bias      = valid_q ? bias_q : '0;
`endif

endmodule

// File: tb/tb_fc_operand_feeder.sv
module tb_fc_operand_feeder;

  localparam int DW = 16;
  localparam int NN = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic [AW:0]   i_len;
  logic [DW-1:0] i_bias;
  logic          o_idle, o_done;
  logic [4*DW-1:0] o_result;
  logic          o_node_ce, o_wegt_ce;
  logic [AW-1:0] o_node_addr, o_wegt_addr;
  logic [DW-1:0] i_node_q, i_wegt_q;
  logic          o_run, o_valid;
  logic [DW-1:0] o_node, o_wegt, o_bias;
  logic [4*DW-1:0] i_core_result;

  logic [DW-1:0] node_mem [NN];
  logic [DW-1:0] wegt_mem [NN];

  int errors = 0;
  int checks = 0;

  fc_operand_feeder #(.IN_DATA_WIDTH(DW), .NUM_NODE(NN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_len(i_len), .i_bias(i_bias),
    .o_idle(o_idle), .o_done(o_done), .o_result(o_result),
    .o_node_ce(o_node_ce), .o_wegt_ce(o_wegt_ce),
    .o_node_addr(o_node_addr), .o_wegt_addr(o_wegt_addr),
    .i_node_q(i_node_q), .i_wegt_q(i_wegt_q),
    .o_run(o_run), .o_valid(o_valid), .o_node(o_node), .o_wegt(o_wegt),
    .o_bias(o_bias), .i_core_result(i_core_result)
  );

  always #5 clk = ~clk;

  // Synchronous read memories and a behavioural MAC core.
  initial begin
    i_node_q = '0;
    i_wegt_q = '0;
    i_core_result = 64'hDEAD_BEEF_0BAD_F00D;
  end

  always @(posedge clk) begin
    if (o_node_ce) i_node_q <= node_mem[o_node_addr];
    if (o_wegt_ce) i_wegt_q <= wegt_mem[o_wegt_addr];
    if (o_run) i_core_result <= '0;
    else if (o_valid)
      i_core_result <= i_core_result + 64'(o_node) * 64'(o_wegt) + 64'(o_bias);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NN; i++) begin
      node_mem[i] = DW'($urandom);
      wegt_mem[i] = DW'($urandom);
    end
  endtask

  // Called at posedge+1 in an IDLE cycle. Reaches the IDLE cycle after DONE.
  task automatic run_job(input string name, input int len, input logic [DW-1:0] bias,
                         input bit hold, input int rst_cyc);
    int leff, c, b, done_cyc, run_cnt, run_bad, ce_cnt, val_cnt, seq_bad, beat_bad, idle_bad;
    logic exp_ce, exp_v;
    logic [63:0] exp_res;
    logic [DW-1:0] exp_b;
    leff = (len > NN) ? NN : len;
    exp_res = '0;
    for (int k = 0; k < leff; k++) begin
      exp_res += 64'(node_mem[k]) * 64'(wegt_mem[k]);
`ifdef FC_BIAS_ONCE_EN
      if (k == 0) exp_res += 64'(bias);
`else
      exp_res += 64'(bias);
`endif
    end
    done_cyc = -1; run_cnt = 0; run_bad = 0; ce_cnt = 0; val_cnt = 0;
    seq_bad = 0; beat_bad = 0; idle_bad = 0;

    i_start = 1'b1;
    i_len   = (AW+1)'(len);
    i_bias  = bias;
    @(posedge clk); #1;
    if (!hold) i_start = 1'b0;
    c = 1;
    while (done_cyc < 0 && c <= leff + 10) begin
      if (c == rst_cyc) begin
        reset = 1'b1;
        #1;
        check({name, "_rst_idle"}, 64'(o_idle), 64'd1);
        check({name, "_rst_ctl"},
              64'({o_done, o_run, o_valid, o_node_ce, o_wegt_ce, o_node_addr, o_wegt_addr}), 64'd0);
        check({name, "_rst_result"}, o_result, 64'd0);
        check({name, "_rst_ops"}, 64'({o_node, o_wegt, o_bias}), 64'd0);
        i_start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (hold && c == 3) begin
        i_len  = (AW+1)'($urandom_range(0, 127));
        i_bias = DW'($urandom);
      end
      exp_ce = (c >= 2) && (c <= leff + 1);
      if (o_node_ce !== exp_ce || o_wegt_ce !== exp_ce) seq_bad++;
      if (exp_ce && (o_node_addr !== AW'(c - 2) || o_wegt_addr !== AW'(c - 2))) seq_bad++;
      if (o_node_ce === 1'b1) ce_cnt++;
      if (o_run === 1'b1) begin
        run_cnt++;
        if (c != 1) run_bad++;
      end
      exp_v = (c >= 3) && (c <= leff + 2);
      if (o_valid !== exp_v) beat_bad++;
      if (o_valid === 1'b1) begin
        val_cnt++;
        b = c - 3;
        if (b >= 0 && b < NN) begin
`ifdef FC_BIAS_ONCE_EN
          exp_b = (b == 0) ? bias : '0;
`else
          exp_b = bias;
`endif
          if (o_node !== node_mem[b] || o_wegt !== wegt_mem[b] || o_bias !== exp_b) beat_bad++;
        end
      end else if (o_bias !== '0) begin
        beat_bad++;
      end
      if (o_idle !== 1'b0) idle_bad++;
      if (o_done === 1'b1) done_cyc = c;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    check({name, "_done_cycle"}, 64'(done_cyc), 64'(leff + 4));
    check({name, "_run_pulses"}, 64'(run_cnt), 64'd1);
    check({name, "_run_cycle"}, 64'(run_bad), 64'd0);
    check({name, "_ce_count"}, 64'(ce_cnt), 64'(leff));
    check({name, "_addr_seq"}, 64'(seq_bad), 64'd0);
    check({name, "_valid_count"}, 64'(val_cnt), 64'(leff));
    check({name, "_beats"}, 64'(beat_bad), 64'd0);
    check({name, "_busy"}, 64'(idle_bad), 64'd0);
    check({name, "_result"}, o_result, exp_res);
    @(posedge clk); #1;
    check({name, "_idle_after"}, 64'({o_idle, o_done, o_run}), 64'b100);
    check({name, "_result_held"}, o_result, exp_res);
  endtask

  initial begin
    reset   = 1'b1;
    i_start = 1'b0;
    i_len   = '0;
    i_bias  = '0;
    fill_rand();
    repeat (3) @(posedge clk);
    #1;
    check("reset_idle", 64'(o_idle), 64'd1);
    check("reset_ctl", 64'({o_done, o_run, o_valid, o_node_ce, o_wegt_ce}), 64'd0);
    check("reset_result", o_result, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed: len 4, bias 10
    for (int i = 0; i < 4; i++) begin
      node_mem[i] = DW'(i + 1);
      wegt_mem[i] = DW'(i + 5);
    end
    run_job("len4", 4, 16'd10, 1'b0, 0);
`ifdef FC_BIAS_ONCE_EN
    check("len4_const", o_result, 64'd80);
`else
    check("len4_const", o_result, 64'd110);
`endif

    node_mem[0] = 16'hFFFF;
    wegt_mem[0] = 16'hFFFF;
    run_job("len1", 1, 16'd0, 1'b0, 0);
    check("len1_const", o_result, 64'hFFFE_0001);

    run_job("len0", 0, 16'h1234, 1'b0, 0);
    check("len0_const", o_result, 64'd0);

    fill_rand();
    run_job("clamp", NN + 5, DW'($urandom), 1'b0, 0);

    // Start held high with mid-job len/bias changes, then back-to-back job
    fill_rand();
    run_job("hold", 6, DW'($urandom), 1'b1, 0);
    run_job("b2b", 3, DW'($urandom), 1'b0, 0);

    // Reset during FETCH beat 2 (cycle 3), then a job that relies on CLEAR
    run_job("midrst", 5, 16'd7, 1'b0, 3);
    node_mem[0] = 16'd3; node_mem[1] = 16'd4;
    wegt_mem[0] = 16'd2; wegt_mem[1] = 16'd2;
    run_job("after_rst", 2, 16'd0, 1'b0, 0);
    check("after_rst_const", o_result, 64'd14);

    for (int j = 0; j < 8; j++) begin
      fill_rand();
      run_job($sformatf("rand%0d", j), int'($urandom_range(0, 80)), DW'($urandom), 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
